// File: rtl/lif_neuron_sequencer_if.sv
// Handshake and data bundle between the LIF neuron sequencer and its
// post-synaptic buffer / controller. The sequencer uses the master modport.
interface lif_neuron_sequencer_if #(
    parameter int unsigned NUM_NEURON = 18
);
    logic                     i_start;
    logic                     i_init;
    logic                     i_clr;
    logic [NUM_NEURON*16-1:0] i_current;
    logic [4:0]               i_inhbt;
    logic                     o_valid;
    logic                     o_spike;
    logic [4:0]               o_neuron_idx;
    logic                     o_s_init;
    logic                     o_cnt_clr;
    logic                     o_busy;
    logic                     o_done;

    modport master (
        input  i_start, i_init, i_clr, i_current, i_inhbt,
        output o_valid, o_spike, o_neuron_idx, o_s_init, o_cnt_clr, o_busy, o_done
    );

    modport slave (
        output i_start, i_init, i_clr, i_current, i_inhbt,
        input  o_valid, o_spike, o_neuron_idx, o_s_init, o_cnt_clr, o_busy, o_done
    );
endinterface

// File: rtl/lif_neuron_sequencer.sv
// Time-multiplexed leaky-integrate-and-fire neuron sequencer. One shared
// datapath sweeps the neuron indices one per cycle; each result is emitted as
// a registered valid/spike/index beat towards the post-synaptic buffer.
module lif_neuron_sequencer #(
    parameter int unsigned NUM_NEURON = 18,
    parameter logic [15:0] V_TH       = 16'd4096,
    parameter int unsigned LEAK_SHIFT = 4,
    parameter logic [15:0] INH_W      = 16'd256,
    parameter int unsigned REFRAC     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lif_neuron_sequencer_if.master bus
);
    localparam logic [4:0] LAST_IDX = 5'(NUM_NEURON - 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         r_idx;
    logic [4:0]         r_inh_q;
    logic [15:0]        r_v [NUM_NEURON];
    logic [2:0]         r_r [NUM_NEURON];
    logic               r_clr_q;

    logic               r_valid;
    logic               r_spike;
    logic [4:0]         r_idx_out;
    logic               r_s_init;
    logic               r_cnt_clr;
    logic               r_busy;
    logic               r_done;

    logic               w_last;
    logic               w_take_init;
    logic               w_take_clr;
    logic               w_take_start;

    logic signed [15:0] w_cur;
    logic [15:0]        w_v;
    logic [2:0]         w_r;
    logic signed [21:0] w_v_s;
    logic signed [21:0] w_leak_s;
    logic signed [21:0] w_cur_s;
    logic signed [21:0] w_inh_s;
    logic signed [21:0] w_t;
    logic [15:0]        w_t_sat;
    logic               w_fire;

    // Membrane potential is kept as unsigned 16 bit; negative sums floor at 0.
    function automatic logic [15:0] sat_u16(input logic signed [21:0] x);
        logic [15:0] y;
        if (x < 22'sd0) begin
            y = 16'd0;
        end else if (x > 22'sd65535) begin
            y = 16'hFFFF;
        end else begin
            y = x[15:0];
        end
        return y;
    endfunction

    // Requests are only honoured in IDLE; init beats clear, clear beats start.
    assign w_last       = (r_idx == LAST_IDX);
    assign w_take_init  = (r_state == IDLE) && bus.i_init;
    assign w_take_clr   = (r_state == IDLE) && !bus.i_init && bus.i_clr;
    assign w_take_start = (r_state == IDLE) && !bus.i_init && !bus.i_clr && bus.i_start;

    // Shared neuron datapath for the neuron currently addressed by r_idx.
    assign w_cur    = bus.i_current[{r_idx, 4'd0} +: 16];
    assign w_v      = r_v[r_idx];
    assign w_r      = r_r[r_idx];
    assign w_v_s    = $signed({6'd0, w_v});
    assign w_leak_s = $signed({6'd0, (w_v >> LEAK_SHIFT)});
    assign w_cur_s  = {{6{w_cur[15]}}, w_cur};
    assign w_inh_s  = $signed({6'd0, INH_W} * {17'd0, r_inh_q});
    assign w_t      = w_v_s - w_leak_s + w_cur_s - w_inh_s;
    assign w_t_sat  = sat_u16(w_t);
    assign w_fire   = (w_t_sat >= V_TH);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: sweeps last NUM_NEURON cycles, then one DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_init) begin
                    w_state_nxt = INIT;
                end else if (w_take_start) begin
                    w_state_nxt = RUN;
                end
            end
            INIT, RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Neuron state update and registered output beats; reset wipes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_inh_q   <= '0;
            r_clr_q   <= 1'b0;
            r_valid   <= 1'b0;
            r_spike   <= 1'b0;
            r_idx_out <= '0;
            r_s_init  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            for (int n = 0; n < NUM_NEURON; n++) begin
                r_v[n] <= '0;
                r_r[n] <= '0;
            end
        end else begin
            // The clear request is acknowledged one edge after it is taken.
            r_clr_q   <= w_take_clr;
            r_cnt_clr <= r_clr_q;
            r_valid   <= 1'b0;
            r_spike   <= 1'b0;
            r_idx_out <= '0;
            r_s_init  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    if (w_take_start) begin
                        r_inh_q <= bus.i_inhbt;
                    end
                end
                INIT: begin
                    r_v[r_idx] <= '0;
                    r_r[r_idx] <= '0;
                    r_valid    <= 1'b1;
                    r_s_init   <= 1'b1;
                    r_idx_out  <= r_idx;
                    r_busy     <= 1'b1;
                    r_idx      <= w_last ? 5'd0 : r_idx + 5'd1;
                end
                RUN: begin
                    r_valid   <= 1'b1;
                    r_idx_out <= r_idx;
                    r_busy    <= 1'b1;
                    if (w_r != 3'd0) begin
                        r_r[r_idx] <= w_r - 3'd1;
                        r_v[r_idx] <= '0;
                    end else if (w_fire) begin
                        r_spike    <= 1'b1;
                        r_v[r_idx] <= '0;
                        r_r[r_idx] <= 3'(REFRAC);
                    end else begin
                        r_v[r_idx] <= w_t_sat;
                    end
                    r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b1;
                    r_idx  <= '0;
                end
                default: r_idx <= '0;
            endcase
        end
    end

    assign bus.o_valid      = r_valid;
    assign bus.o_spike      = r_spike;
    assign bus.o_neuron_idx = r_idx_out;
    assign bus.o_s_init     = r_s_init;
    assign bus.o_cnt_clr    = r_cnt_clr;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
endmodule
